wiphase_cpu_debug_ocimem: RTL and testbench

- Debug-side on-chip memory (OCI RAM) controller that sits directly downstream of the CPU debug slave wrapper.
- Consumes the wrapper's sysclk-domain command pulses (take_action_ocimem_a/b, take_no_action_ocimem_a) and the 38-bit jdo payload.
- Executes JTAG reads and writes into a 256x32 debug RAM and returns read data on MonDReg, which feeds back into the wrapper's scan chain.
- Also serves the CPU's Avalon-MM debug slave port into the same RAM, with JTAG commands having priority.

---
 rtl/wiphase_cpu_debug_ocimem_pkg.sv | 20 ++
 rtl/wiphase_cpu_debug_ocimem_ram.sv | 27 ++
 rtl/wiphase_cpu_debug_ocimem.sv | 159 +++++++++++++++
 tb/tb_wiphase_cpu_debug_ocimem.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wiphase_cpu_debug_ocimem_pkg.sv
// Shared types and constants for the debug OCI RAM controller.
// Covers the FSM state, the JTAG command kinds and the jdo field positions.
package wiphase_ocimem_pkg;

   localparam int OCI_ADDR_W  = 8;
   localparam int OCI_DEPTH   = 1 << OCI_ADDR_W;
   localparam int OCI_DATA_W  = 32;
   localparam int JDO_W       = 38;

   localparam int ADDR_LSB    = 17;
   localparam int RD_BIT      = 34;
   localparam int AUTOINC_BIT = 35;
   localparam int WDATA_LSB   = 3;

   typedef enum logic [1:0] {IDLE, JRD, AVRD1, AVRD2} state_e;

   // LOAD = take_action_ocimem_a, WRITE = take_action_ocimem_b, READ = take_no_action_ocimem_a
   typedef enum logic [1:0] {CMD_NONE, CMD_LOAD, CMD_READ, CMD_WRITE} jcmd_e;

endpackage

// File: rtl/wiphase_cpu_debug_ocimem_ram.sv
// Single-port debug RAM with per-byte write enables and a registered read port.
// Each byte lane has its own storage array, so there is one writer per array.
module wiphase_cpu_debug_ocimem_ram #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic [ADDR_W-1:0]   addr,
   input  logic                we,
   input  logic [DATA_W/8-1:0] be,
   input  logic [DATA_W-1:0]   wdata,
   output logic [DATA_W-1:0]   q
);

   for (genvar b = 0; b < DATA_W/8; b++) begin : g_lane
      logic [7:0] mem [DEPTH];

      always_ff @(posedge clk) begin
         if (we && be[b]) begin
            mem[addr] <= wdata[b*8 +: 8];
         end
         q[b*8 +: 8] <= mem[addr];
      end
   end

endmodule

// File: rtl/wiphase_cpu_debug_ocimem.sv
// Debug OCI RAM controller: executes JTAG commands from the debug slave wrapper and
// serves the Avalon-MM debug slave port into one shared RAM, with JTAG taking priority.
module wiphase_cpu_debug_ocimem
   import wiphase_ocimem_pkg::*;
#(
   parameter int ADDR_W = OCI_ADDR_W,
   parameter int DEPTH  = OCI_DEPTH,
   parameter int DATA_W = OCI_DATA_W
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [JDO_W-1:0]    jdo,
   input  logic                take_action_ocimem_a,
   input  logic                take_action_ocimem_b,
   input  logic                take_no_action_ocimem_a,
   output logic [DATA_W-1:0]   MonDReg,
   input  logic [ADDR_W-1:0]   address,
   input  logic                chipselect,
   input  logic                read,
   input  logic                write,
   input  logic [DATA_W-1:0]   writedata,
   input  logic [DATA_W/8-1:0] byteenable,
   input  logic                debugaccess,
   output logic [DATA_W-1:0]   readdata,
   output logic                waitrequest
);

   state_e              state;
   logic [ADDR_W-1:0]   mon_a_reg;
   logic                autoinc;
   logic                pend_valid;
   jcmd_e               pend_kind;
   logic [JDO_W-1:0]    pend_jdo;

   jcmd_e               new_kind, exec_kind;
   logic [JDO_W-1:0]    exec_jdo;
   logic [ADDR_W-1:0]   ex_addr, jtag_addr;
   logic                ex_rd, ex_inc, jtag_rd, jtag_wr, jtag_access;
   logic [DATA_W-1:0]   ex_wdata;
   logic                av_sel, av_rd_start, av_wr, av_done;
   logic                unused_jdo_bits;

   logic [ADDR_W-1:0]   ram_addr;
   logic                ram_we;
   logic [DATA_W/8-1:0] ram_be;
   logic [DATA_W-1:0]   ram_wdata, ram_q;

   always_comb begin
      new_kind = CMD_NONE;
      if (take_action_ocimem_a)         new_kind = CMD_LOAD;
      else if (take_action_ocimem_b)    new_kind = CMD_WRITE;
      else if (take_no_action_ocimem_a) new_kind = CMD_READ;
   end

   // In IDLE a parked command always goes ahead of a freshly arriving pulse.
   always_comb begin
      exec_kind = CMD_NONE;
      exec_jdo  = jdo;
      if (state == IDLE) begin
         if (pend_valid) begin
            exec_kind = pend_kind;
            exec_jdo  = pend_jdo;
         end else begin
            exec_kind = new_kind;
         end
      end
   end

   assign ex_addr         = exec_jdo[ADDR_LSB +: ADDR_W];
   assign ex_rd           = exec_jdo[RD_BIT];
   assign ex_inc          = exec_jdo[AUTOINC_BIT];
   assign ex_wdata        = exec_jdo[WDATA_LSB +: DATA_W];
   assign unused_jdo_bits = ^{exec_jdo[JDO_W-1:AUTOINC_BIT+1], exec_jdo[WDATA_LSB-1:0]};

   assign jtag_rd     = (exec_kind == CMD_READ) || ((exec_kind == CMD_LOAD) && ex_rd);
   assign jtag_wr     = (exec_kind == CMD_WRITE);
   assign jtag_access = jtag_rd || jtag_wr;
   assign jtag_addr   = (exec_kind == CMD_LOAD) ? ex_addr : mon_a_reg;

   assign av_sel      = (state == IDLE) && (exec_kind == CMD_NONE) && chipselect;
   assign av_rd_start = av_sel && read;
   assign av_wr       = av_sel && write && !read;
   assign av_done     = av_wr || (state == AVRD2);
   assign waitrequest = chipselect && (read || write) && !av_done;

   always_comb begin
      ram_addr  = address;
      ram_we    = av_wr && debugaccess;
      ram_be    = byteenable;
      ram_wdata = writedata;
      if (exec_kind != CMD_NONE) begin
         ram_addr  = jtag_addr;
         ram_we    = jtag_wr;
         ram_be    = '1;
         ram_wdata = ex_wdata;
      end
   end

   wiphase_cpu_debug_ocimem_ram #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk   (clk),
      .addr  (ram_addr),
      .we    (ram_we),
      .be    (ram_be),
      .wdata (ram_wdata),
      .q     (ram_q)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         MonDReg    <= '0;
         readdata   <= '0;
         mon_a_reg  <= '0;
         autoinc    <= 1'b0;
         pend_valid <= 1'b0;
         pend_kind  <= CMD_NONE;
         pend_jdo   <= '0;
      end else begin
         assert (!(pend_valid && (new_kind != CMD_NONE)));

         case (state)
            IDLE: begin
               if (jtag_rd)          state <= JRD;
               else if (av_rd_start) state <= AVRD1;
            end
            JRD: begin
               MonDReg <= ram_q;
               state   <= IDLE;
            end
            AVRD1: begin
               readdata <= ram_q;
               state    <= AVRD2;
            end
            AVRD2: state <= IDLE;
         endcase

         // A LOAD sets the address and flag together, so its own read steps from the new address.
         if (exec_kind == CMD_LOAD) begin
            autoinc   <= ex_inc;
            mon_a_reg <= (ex_inc && ex_rd) ? ex_addr + 1'b1 : ex_addr;
         end else if (jtag_access && autoinc) begin
            mon_a_reg <= mon_a_reg + 1'b1;
         end

         if (state != IDLE && new_kind != CMD_NONE) begin
            pend_valid <= 1'b1;
            pend_kind  <= new_kind;
            pend_jdo   <= jdo;
         end else if (state == IDLE) begin
            pend_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_wiphase_cpu_debug_ocimem.sv
// Directed plus randomized bench for the debug OCI RAM controller, checked against
// a word-array model of the RAM and the JTAG address register.
module tb_wiphase_cpu_debug_ocimem;

   logic        clk;
   logic        reset_n;
   logic [37:0] jdo;
   logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
   logic [31:0] MonDReg, readdata, writedata;
   logic [7:0]  address;
   logic        chipselect, read, write, debugaccess, waitrequest;
   logic [3:0]  byteenable;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   logic [31:0] mem_m [256];
   logic [7:0]  mon_a_m;
   logic        inc_m;
   logic [31:0] mond_m;

   wiphase_cpu_debug_ocimem dut (
      .clk                     (clk),
      .reset_n                 (reset_n),
      .jdo                     (jdo),
      .take_action_ocimem_a    (take_action_ocimem_a),
      .take_action_ocimem_b    (take_action_ocimem_b),
      .take_no_action_ocimem_a (take_no_action_ocimem_a),
      .MonDReg                 (MonDReg),
      .address                 (address),
      .chipselect              (chipselect),
      .read                    (read),
      .write                   (write),
      .writedata               (writedata),
      .byteenable              (byteenable),
      .debugaccess             (debugaccess),
      .readdata                (readdata),
      .waitrequest             (waitrequest)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [37:0] jdo_load(input logic [7:0] a, input logic rd, input logic inc);
      logic [37:0] j;
      j        = '0;
      j[24:17] = a;
      j[34]    = rd;
      j[35]    = inc;
      return j;
   endfunction

   function automatic logic [37:0] jdo_data(input logic [31:0] d);
      logic [37:0] j;
      j       = '0;
      j[34:3] = d;
      return j;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
      logic [31:0] mask;
      mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      return (old & ~mask) | (d & mask);
   endfunction

   // kind: 0 = take_action_a, 1 = take_action_b, 2 = take_no_action_a
   task automatic pulse(input int kind, input logic [37:0] j);
      jdo                     = j;
      take_action_ocimem_a    = (kind == 0);
      take_action_ocimem_b    = (kind == 1);
      take_no_action_ocimem_a = (kind == 2);
      tick();
      take_action_ocimem_a    = 1'b0;
      take_action_ocimem_b    = 1'b0;
      take_no_action_ocimem_a = 1'b0;
   endtask

   // Entered one cycle after the read pulse: old value still held, new value one cycle later.
   task automatic expect_mond(input string tag, input logic [31:0] prev);
      check({tag, "_early"}, MonDReg, prev);
      tick();
      check(tag, MonDReg, mond_m);
   endtask

   task automatic jtag_load(input logic [7:0] a, input logic rd, input logic inc, input string tag);
      logic [31:0] prev;
      prev    = mond_m;
      mon_a_m = a;
      inc_m   = inc;
      if (rd) mond_m = mem_m[a];
      pulse(0, jdo_load(a, rd, inc));
      if (rd) expect_mond(tag, prev);
   endtask

   task automatic jtag_write(input logic [31:0] d);
      pulse(1, jdo_data(d));
      mem_m[mon_a_m] = d;
      if (inc_m) mon_a_m = mon_a_m + 8'd1;
   endtask

   task automatic jtag_read(input string tag);
      logic [31:0] prev;
      prev   = mond_m;
      mond_m = mem_m[mon_a_m];
      if (inc_m) mon_a_m = mon_a_m + 8'd1;
      pulse(2, '0);
      expect_mond(tag, prev);
   endtask

   task automatic av_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                           input logic dbg, input string tag);
      address     = a;
      writedata   = d;
      byteenable  = be;
      debugaccess = dbg;
      chipselect  = 1'b1;
      write       = 1'b1;
      #1;
      check({tag, "_wait"}, {31'b0, waitrequest}, 32'd0);
      if (dbg) mem_m[a] = merge(mem_m[a], d, be);
      tick();
      chipselect = 1'b0;
      write      = 1'b0;
   endtask

   task automatic av_read(input logic [7:0] a, input string tag);
      int unsigned waits;
      waits      = 0;
      address    = a;
      chipselect = 1'b1;
      read       = 1'b1;
      #1;
      while (waitrequest !== 1'b0 && waits < 8) begin
         tick();
         #1;
         waits++;
      end
      check({tag, "_waits"}, waits, 32'd2);
      check(tag, readdata, mem_m[a]);
      tick();
      chipselect = 1'b0;
      read       = 1'b0;
   endtask

   initial begin
      logic [31:0] prev;
      logic [7:0]  ra;
      logic        rinc, rrd;

      reset_n = 1'b0;
      jdo = '0;
      take_action_ocimem_a = 1'b0;
      take_action_ocimem_b = 1'b0;
      take_no_action_ocimem_a = 1'b0;
      address = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
      writedata = '0; byteenable = '0; debugaccess = 1'b0;
      mon_a_m = '0; inc_m = 1'b0; mond_m = '0;

      repeat (3) tick();
      check("rst_mondreg", MonDReg, 32'd0);
      check("rst_readdata", readdata, 32'd0);
      check("rst_waitreq", {31'b0, waitrequest}, 32'd0);
      reset_n = 1'b1;
      tick();

      for (int i = 0; i < 256; i++) av_write(i[7:0], $urandom, 4'hF, 1'b1, "init");

      // JTAG write then read back
      jtag_load(8'h10, 1'b0, 1'b0, "t1_load");
      jtag_write(32'hDEADBEEF);
      jtag_read("t1_read");
      check("t1_const", MonDReg, 32'hDEADBEEF);

      // Auto-increment wrap 0xFF -> 0x00
      jtag_load(8'hFF, 1'b0, 1'b1, "wrap_load");
      jtag_write(32'h11111111);
      jtag_write(32'h22222222);
      jtag_read("wrap_monareg_01");
      jtag_load(8'hFF, 1'b1, 1'b0, "wrap_ff");
      check("wrap_ff_const", MonDReg, 32'h11111111);
      jtag_load(8'h00, 1'b1, 1'b0, "wrap_00");
      check("wrap_00_const", MonDReg, 32'h22222222);

      // Avalon byte enables and debugaccess qualification
      av_write(8'd3, 32'hFFFFFFFF, 4'hF, 1'b1, "av_fill");
      av_write(8'd3, 32'hA5A5A5A5, 4'b0011, 1'b1, "av_be");
      av_read(8'd3, "av_be_rd");
      check("av_be_const", readdata, 32'hFFFFA5A5);
      av_write(8'd3, 32'h12345678, 4'hF, 1'b0, "av_nodbg");
      av_read(8'd3, "av_nodbg_rd");
      check("av_nodbg_const", readdata, 32'hFFFFA5A5);

      // Collision: JTAG load+read arrives while an Avalon read is in flight
      av_write(8'd5, 32'h5555AAAA, 4'hF, 1'b1, "col_prep");
      address = 8'd7; chipselect = 1'b1; read = 1'b1;
      #1;
      check("col_wait0", {31'b0, waitrequest}, 32'd1);
      tick();
      jdo = jdo_load(8'd5, 1'b1, 1'b0);
      take_action_ocimem_a = 1'b1;
      #1;
      check("col_wait1", {31'b0, waitrequest}, 32'd1);
      tick();
      take_action_ocimem_a = 1'b0;
      #1;
      check("col_wait2", {31'b0, waitrequest}, 32'd0);
      check("col_av_data", readdata, mem_m[7]);
      tick();
      chipselect = 1'b0; read = 1'b0;
      prev = mond_m; mond_m = mem_m[5]; mon_a_m = 8'd5; inc_m = 1'b0;
      tick();
      expect_mond("col_jtag", prev);

      // Priority: JTAG write and Avalon write in the same IDLE cycle
      jtag_load(8'h20, 1'b0, 1'b0, "pri_load");
      address = 8'd9; writedata = 32'h0BADF00D; byteenable = 4'hF; debugaccess = 1'b1;
      chipselect = 1'b1; write = 1'b1;
      jdo = jdo_data(32'h600DCAFE);
      take_action_ocimem_b = 1'b1;
      #1;
      check("pri_wait0", {31'b0, waitrequest}, 32'd1);
      tick();
      take_action_ocimem_b = 1'b0;
      mem_m[8'h20] = 32'h600DCAFE;
      #1;
      check("pri_wait1", {31'b0, waitrequest}, 32'd0);
      mem_m[9] = 32'h0BADF00D;
      tick();
      chipselect = 1'b0; write = 1'b0;
      av_read(8'd9, "pri_av");
      jtag_load(8'h20, 1'b1, 1'b0, "pri_jtag");

      // Randomized mix
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 4))
            0: begin
               ra   = 8'($urandom);
               rinc = 1'($urandom);
               rrd  = rinc ? 1'b0 : 1'($urandom);
               jtag_load(ra, rrd, rinc, "rnd_load");
            end
            1: jtag_write($urandom);
            2: jtag_read("rnd_jread");
            3: av_write(8'($urandom), $urandom, 4'($urandom), 1'($urandom), "rnd_awr");
            default: av_read(8'($urandom), "rnd_ard");
         endcase
      end

      // Reset during JRD abandons the read
      av_write(8'h30, 32'hCAFEF00D, 4'hF, 1'b1, "rjrd_prep");
      pulse(0, jdo_load(8'h30, 1'b1, 1'b0));
      reset_n = 1'b0;
      #1;
      check("rjrd_mond", MonDReg, 32'd0);
      check("rjrd_rdata", readdata, 32'd0);
      mond_m = '0; mon_a_m = '0; inc_m = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      tick();
      check("rjrd_no_update", MonDReg, 32'd0);
      jtag_read("rjrd_monareg0");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
